// File: rtl/agc_arb_pkg.sv
// Shared types and constants for the agc_ram Core/host port arbiter.
package agc_arb_pkg;

  localparam int unsigned RAM_ADDR_W = 11;
  localparam int unsigned DATA_W     = 15;
  localparam int unsigned WDOG_LIMIT = 256;

  typedef enum logic [1:0] {
    CORE_OWN = 2'd0,
    DRAIN    = 2'd1,
    HOST_OWN = 2'd2,
    RETURN   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/agc_ram_arbiter_if.sv
// Core, host and agc_ram signal bundle around the arbiter.
// host_timeout exists only when AGC_RAM_ARB_WATCHDOG_EN is defined.
interface agc_ram_arbiter_if;
  import agc_arb_pkg::*;

  logic [RAM_ADDR_W-1:0] core_rd_addr;
  logic [RAM_ADDR_W-1:0] core_wr_addr;
  logic [DATA_W-1:0]     core_wr_data;
  logic                  core_wr_en;
  logic                  core_stall;
  logic                  core_halted;
  logic                  core_pause;

  logic                  host_req;
  logic                  host_gnt;
  logic                  host_valid;
  logic                  host_ready;
  logic                  host_we;
  logic [RAM_ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic                  host_done;
  logic                  host_rsp_valid;
  logic [DATA_W-1:0]     host_rdata;
`ifdef AGC_RAM_ARB_WATCHDOG_EN
  logic                  host_timeout;
`endif

  logic [RAM_ADDR_W-1:0] ram_rd_addr;
  logic [RAM_ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0]     ram_wr_data;
  logic                  ram_wr_en;
  logic                  ram_addr_stall;
  logic [DATA_W-1:0]     ram_rd_data;

  modport slave (
    input  core_rd_addr, core_wr_addr, core_wr_data, core_wr_en, core_stall, core_halted,
    input  host_req, host_valid, host_we, host_addr, host_wdata, host_done, ram_rd_data,
    output core_pause, host_gnt, host_ready, host_rsp_valid, host_rdata,
`ifdef AGC_RAM_ARB_WATCHDOG_EN
    output host_timeout,
`endif
    output ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en, ram_addr_stall
  );

  modport master (
    output core_rd_addr, core_wr_addr, core_wr_data, core_wr_en, core_stall, core_halted,
    output host_req, host_valid, host_we, host_addr, host_wdata, host_done, ram_rd_data,
    input  core_pause, host_gnt, host_ready, host_rsp_valid, host_rdata,
`ifdef AGC_RAM_ARB_WATCHDOG_EN
    input  host_timeout,
`endif
    input  ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en, ram_addr_stall
  );

endinterface

// File: rtl/agc_arb_rsp_pipe.sv
// Read-tag shift register matching RAM read latency, plus in-flight read count.
module agc_arb_rsp_pipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tag_in,
  output logic tag_out,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

  logic [RD_LATENCY-1:0] tag_sr;
  logic [CNT_W-1:0]      in_flight;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_sr    <= '0;
      in_flight <= '0;
    end else begin
      tag_sr    <= (tag_sr << 1) | RD_LATENCY'(tag_in);
      in_flight <= in_flight + CNT_W'(tag_in) - CNT_W'(tag_out);
    end
  end

  assign tag_out = tag_sr[RD_LATENCY-1];
  assign busy    = (in_flight != '0);

endmodule

// File: rtl/agc_ram_arbiter.sv
// Shares the agc_ram port between the AGC Core and an external host.
// Optional host idle watchdog: define AGC_RAM_ARB_WATCHDOG_EN.
module agc_ram_arbiter
  import agc_arb_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES    = 3,
  parameter int unsigned BURST_MAX       = 16,
  parameter int unsigned MIN_CORE_CYCLES = 32,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  agc_ram_arbiter_if.slave  bus
);

  localparam int unsigned DRAIN_W = $clog2(PAUSE_CYCLES + 1);
  localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);
  localparam int unsigned COOL_W  = $clog2(MIN_CORE_CYCLES + 1);

  arb_state_t         state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [COOL_W-1:0]  cooldown;
  logic               release_q;
  logic               ready_c, accept, rd_accept, done_c;
  logic               rsp_tag, rsp_busy, wd_fire;

  assign ready_c   = (state == HOST_OWN) && (burst_cnt < BURST_W'(BURST_MAX)) && !release_q;
  assign accept    = bus.host_valid && ready_c;
  assign rd_accept = accept && !bus.host_we;
  assign done_c    = release_q || bus.host_done || wd_fire || (burst_cnt == BURST_W'(BURST_MAX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= CORE_OWN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CORE_OWN: if (bus.host_req && (cooldown == '0))
                  state_nxt = bus.core_halted ? HOST_OWN : DRAIN;
      DRAIN:    if (!bus.host_req)                                state_nxt = CORE_OWN;
                else if (drain_cnt == DRAIN_W'(PAUSE_CYCLES - 1)) state_nxt = HOST_OWN;
      // Hold the grant until every accepted read has returned its data.
      HOST_OWN: if (done_c && !rsp_busy && !rd_accept)            state_nxt = RETURN;
      RETURN:   state_nxt = CORE_OWN;
      default:  state_nxt = CORE_OWN;
    endcase
  end

  always_comb begin
    bus.core_pause     = 1'b0;
    bus.host_gnt       = 1'b0;
    bus.host_ready     = 1'b0;
    bus.ram_rd_addr    = bus.core_rd_addr;
    bus.ram_wr_addr    = bus.core_wr_addr;
    bus.ram_wr_data    = bus.core_wr_data;
    bus.ram_wr_en      = bus.core_wr_en;
    bus.ram_addr_stall = bus.core_stall;
    bus.host_rsp_valid = rsp_tag;
    bus.host_rdata     = rsp_tag ? bus.ram_rd_data : '0;
    case (state)
      DRAIN, RETURN: bus.core_pause = 1'b1;
      HOST_OWN: begin
        bus.core_pause     = 1'b1;
        bus.host_gnt       = 1'b1;
        bus.host_ready     = ready_c;
        bus.ram_rd_addr    = bus.host_addr;
        bus.ram_wr_addr    = bus.host_addr;
        bus.ram_wr_data    = bus.host_wdata;
        bus.ram_wr_en      = accept && bus.host_we;
        bus.ram_addr_stall = 1'b0;
      end
      default: ;
    endcase
  end

  // Drain, burst, release and post-release cooldown bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_cnt <= '0;
      burst_cnt <= '0;
      cooldown  <= '0;
      release_q <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
      if (state != HOST_OWN) burst_cnt <= '0;
      else if (accept)       burst_cnt <= burst_cnt + BURST_W'(1);
      if (state != HOST_OWN)                release_q <= 1'b0;
      else if (bus.host_done || wd_fire)    release_q <= 1'b1;
      if (state == RETURN)                                cooldown <= COOL_W'(MIN_CORE_CYCLES);
      else if ((state == CORE_OWN) && (cooldown != '0))   cooldown <= cooldown - COOL_W'(1);
    end
  end

  agc_arb_rsp_pipe #(.RD_LATENCY(RD_LATENCY)) u_rsp_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .tag_in  (rd_accept),
    .tag_out (rsp_tag),
    .busy    (rsp_busy)
  );

`ifdef AGC_RAM_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] idle_cnt;
  logic            idle_c, timeout_q;

  assign idle_c  = (state == HOST_OWN) && !accept && !bus.host_done;
  assign wd_fire = idle_c && (idle_cnt == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_cnt <= (idle_c && !wd_fire) ? idle_cnt + WD_W'(1) : '0;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign bus.host_timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_agc_ram_arbiter.sv
// Directed self-checking bench for agc_ram_arbiter with a behavioural agc_ram.
module tb_agc_ram_arbiter;
  import agc_arb_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  agc_ram_arbiter_if bus ();

  agc_ram_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Registered-output RAM, one cycle read latency.
  logic [DATA_W-1:0] mem [0:2047];
  logic [DATA_W-1:0] ram_q;
  always @(posedge clock) begin
    ram_q <= mem[bus.ram_rd_addr];
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end
  assign bus.ram_rd_data = ram_q;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_rd_addr = 11'h055; bus.core_wr_addr = '0; bus.core_wr_data = '0;
    bus.core_wr_en = 1'b0; bus.core_stall = 1'b0; bus.core_halted = 1'b0;
    bus.host_req = 1'b0; bus.host_valid = 1'b0; bus.host_we = 1'b0;
    bus.host_addr = '0; bus.host_wdata = '0; bus.host_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.core_pause !== 1'b0) begin errors++; $display("FAIL reset_core_pause: got %0b want 0", bus.core_pause); end
    checks++; if (bus.host_gnt !== 1'b0) begin errors++; $display("FAIL reset_host_gnt: got %0b want 0", bus.host_gnt); end
    checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL reset_host_ready: got %0b want 0", bus.host_ready); end
    checks++; if (bus.host_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", bus.host_rsp_valid); end
    checks++; if (bus.host_rdata !== 15'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.host_rdata); end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_core_passthrough();
    bus.core_wr_addr = 11'h010; bus.core_wr_data = 15'h1234; bus.core_wr_en = 1'b1;
    bus.core_rd_addr = 11'h123; bus.core_stall = 1'b1;
    #1;
    checks++; if (bus.ram_wr_en !== 1'b1) begin errors++; $display("FAIL core_wr_en: got %0b want 1", bus.ram_wr_en); end
    checks++; if (bus.ram_wr_addr !== 11'h010) begin errors++; $display("FAIL core_wr_addr: got %h want 010", bus.ram_wr_addr); end
    checks++; if (bus.ram_wr_data !== 15'h1234) begin errors++; $display("FAIL core_wr_data: got %h want 1234", bus.ram_wr_data); end
    checks++; if (bus.ram_rd_addr !== 11'h123) begin errors++; $display("FAIL core_rd_addr: got %h want 123", bus.ram_rd_addr); end
    checks++; if (bus.ram_addr_stall !== 1'b1) begin errors++; $display("FAIL core_stall_fwd: got %0b want 1", bus.ram_addr_stall); end
    checks++; if (bus.host_gnt !== 1'b0) begin errors++; $display("FAIL core_own_gnt: got %0b want 0", bus.host_gnt); end
    tick();
    bus.core_wr_en = 1'b0; bus.core_stall = 1'b0; bus.core_rd_addr = 11'h055;
  endtask

  task automatic test_drain_host_rw();
    int n;
    bus.host_req = 1'b1; bus.core_halted = 1'b0;
    #1;
    checks++; if (bus.core_pause !== 1'b0) begin errors++; $display("FAIL pause_before_req: got %0b want 0", bus.core_pause); end
    tick();
    checks++; if (bus.core_pause !== 1'b1) begin errors++; $display("FAIL drain_pause: got %0b want 1", bus.core_pause); end
    checks++; if (bus.host_gnt !== 1'b0) begin errors++; $display("FAIL drain_gnt: got %0b want 0", bus.host_gnt); end
    checks++; if (bus.ram_rd_addr !== 11'h055) begin errors++; $display("FAIL drain_core_mux: got %h want 055", bus.ram_rd_addr); end
    n = 0;
    while (bus.host_gnt !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL drain_length: got %0d want 3", n); end
    bus.core_stall = 1'b1; bus.core_wr_en = 1'b1; bus.core_wr_addr = 11'h010; bus.core_wr_data = 15'h0AAA;
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'h7FF; bus.host_wdata = 15'h5555;
    #1;
    checks++; if (bus.ram_wr_en !== 1'b1) begin errors++; $display("FAIL host_wr_en: got %0b want 1", bus.ram_wr_en); end
    checks++; if (bus.ram_wr_addr !== 11'h7FF) begin errors++; $display("FAIL host_wr_addr: got %h want 7ff", bus.ram_wr_addr); end
    checks++; if (bus.ram_wr_data !== 15'h5555) begin errors++; $display("FAIL host_wr_data: got %h want 5555", bus.ram_wr_data); end
    checks++; if (bus.ram_addr_stall !== 1'b0) begin errors++; $display("FAIL host_stall: got %0b want 0", bus.ram_addr_stall); end
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL host_ready: got %0b want 1", bus.host_ready); end
    tick();
    bus.host_we = 1'b0; bus.core_wr_en = 1'b0;
    #1;
    checks++; if (bus.ram_rd_addr !== 11'h7FF) begin errors++; $display("FAIL host_rd_addr: got %h want 7ff", bus.ram_rd_addr); end
    checks++; if (bus.host_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_early: got %0b want 0", bus.host_rsp_valid); end
    tick();
    bus.host_valid = 1'b0;
    checks++; if (bus.host_rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_valid: got %0b want 1", bus.host_rsp_valid); end
    checks++; if (bus.host_rdata !== 15'h5555) begin errors++; $display("FAIL rsp_data: got %h want 5555", bus.host_rdata); end
    checks++; if (mem[11'h010] !== 15'h1234) begin errors++; $display("FAIL core_write_dropped: got %h want 1234", mem[11'h010]); end
    tick();
    checks++; if (bus.host_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle: got %0b want 0", bus.host_rsp_valid); end
    bus.host_done = 1'b1;
    tick();
    checks++; if (bus.host_gnt !== 1'b0 || bus.core_pause !== 1'b1) begin errors++; $display("FAIL return_state: got gnt=%0b pause=%0b want gnt=0 pause=1", bus.host_gnt, bus.core_pause); end
    bus.host_done = 1'b0; bus.host_req = 1'b0; bus.core_stall = 1'b0;
    tick();
    checks++; if (bus.core_pause !== 1'b0) begin errors++; $display("FAIL back_to_core: got %0b want 0", bus.core_pause); end
    repeat (40) tick();
  endtask

  task automatic test_halted_grant();
    bus.core_halted = 1'b1; bus.host_req = 1'b1;
    tick();
    checks++; if (bus.host_gnt !== 1'b1) begin errors++; $display("FAIL halted_gnt: got %0b want 1", bus.host_gnt); end
    bus.host_done = 1'b1; bus.host_req = 1'b0;
    tick();
    bus.host_done = 1'b0; bus.core_halted = 1'b0;
    tick();
    repeat (40) tick();
  endtask

  task automatic test_back_to_back();
    int i, accepted, n, guard;
    bus.core_halted = 1'b1; bus.host_req = 1'b1;
    tick();
    bus.host_valid = 1'b1; bus.host_we = 1'b1;
    i = 0; accepted = 0;
    while (bus.host_gnt === 1'b1 && i < 40) begin
      bus.host_addr = 11'(i); bus.host_wdata = 15'(i + 100);
      #1;
      if (bus.host_ready === 1'b1) accepted++;
      tick();
      i++;
    end
    bus.host_valid = 1'b0;
    checks++; if (accepted != 16) begin errors++; $display("FAIL burst_accepted: got %0d want 16", accepted); end
    checks++; if (i != 17) begin errors++; $display("FAIL burst_gnt_cycles: got %0d want 17", i); end
    checks++; if (bus.core_pause !== 1'b1) begin errors++; $display("FAIL burst_return_pause: got %0b want 1", bus.core_pause); end
    checks++; if (mem[15] !== 15'd115) begin errors++; $display("FAIL burst_last_write: got %0d want 115", mem[15]); end
    // 32 cooldown cycles ignore host_req, the 33rd Core cycle accepts it.
    n = 0; guard = 0;
    while (bus.host_gnt !== 1'b1 && guard < 100) begin
      if (bus.core_pause === 1'b0) n++;
      tick();
      guard++;
    end
    checks++; if (n != 33) begin errors++; $display("FAIL cooldown_cycles: got %0d want 33", n); end
    bus.host_done = 1'b1; bus.host_req = 1'b0;
    tick();
    bus.host_done = 1'b0; bus.core_halted = 1'b0;
    tick();
    repeat (40) tick();
  endtask

  task automatic test_done_with_read();
    int n;
    bus.core_halted = 1'b1; bus.host_req = 1'b1;
    tick();
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'h100; bus.host_wdata = 15'h2A5A;
    tick();
    bus.host_we = 1'b0; bus.host_done = 1'b1;
    #1;
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL done_read_ready: got %0b want 1", bus.host_ready); end
    tick();
    bus.host_valid = 1'b0; bus.host_done = 1'b0;
    checks++; if (bus.host_rsp_valid !== 1'b1 || bus.host_rdata !== 15'h2A5A) begin errors++; $display("FAIL done_read_rsp: got v=%0b d=%h want v=1 d=2a5a", bus.host_rsp_valid, bus.host_rdata); end
    checks++; if (bus.host_gnt !== 1'b1) begin errors++; $display("FAIL done_read_gnt_held: got %0b want 1", bus.host_gnt); end
    n = 0;
    while (bus.host_gnt === 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (bus.host_gnt !== 1'b0) begin errors++; $display("FAIL done_read_release: got %0b want 0", bus.host_gnt); end
    bus.host_req = 1'b0; bus.core_halted = 1'b0;
    tick();
    repeat (40) tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.core_halted = 1'b1; bus.host_req = 1'b1;
    tick();
    bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'h7FF;
    #1;
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b want 1", bus.host_ready); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.host_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %0b want 0", bus.host_rsp_valid); end
    checks++; if (bus.host_gnt !== 1'b0 || bus.core_pause !== 1'b0 || bus.host_ready !== 1'b0) begin errors++; $display("FAIL mid_outputs: got gnt=%0b pause=%0b rdy=%0b want 0 0 0", bus.host_gnt, bus.core_pause, bus.host_ready); end
    checks++; if (bus.host_rdata !== 15'h0) begin errors++; $display("FAIL mid_rdata: got %h want 0000", bus.host_rdata); end
    bus.host_valid = 1'b0; bus.host_req = 1'b0; bus.core_halted = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    tick();
    checks++; if (bus.ram_rd_addr !== 11'h055 || bus.host_gnt !== 1'b0) begin errors++; $display("FAIL post_reset_core: got addr=%h gnt=%0b want 055 0", bus.ram_rd_addr, bus.host_gnt); end
    bus.core_halted = 1'b1; bus.host_req = 1'b1;
    tick();
    checks++; if (bus.host_gnt !== 1'b1) begin errors++; $display("FAIL post_reset_no_cooldown: got %0b want 1", bus.host_gnt); end
    bus.host_done = 1'b1; bus.host_req = 1'b0;
    tick();
    bus.host_done = 1'b0; bus.core_halted = 1'b0;
    repeat (40) tick();
  endtask

`ifdef AGC_RAM_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    bus.core_halted = 1'b1; bus.host_req = 1'b1;
    tick();
    bus.host_req = 1'b0;
    checks++; if (bus.host_timeout !== 1'b0) begin errors++; $display("FAIL wd_initial: got %0b want 0", bus.host_timeout); end
    n = 0;
    while (bus.host_gnt === 1'b1 && n < 400) begin tick(); n++; end
    checks++; if (n != 256) begin errors++; $display("FAIL wd_idle_cycles: got %0d want 256", n); end
    checks++; if (bus.host_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0b want 1", bus.host_timeout); end
    bus.core_halted = 1'b0;
    repeat (40) tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_core_passthrough();
    test_drain_host_rw();
    test_halted_grant();
    test_back_to_back();
    test_done_with_read();
    test_reset_mid_burst();
`ifdef AGC_RAM_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
